// File: rtl/spi_slave_reg_ctrl.sv
// Command/burst sequencer between a byte-level SPI slave and an on-chip register bus.
// Frame = command byte {RW, ADDR} followed by auto-incrementing register writes or prefetched reads.
module spi_slave_reg_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int ADDR_W    = 7,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs_active,
  input  logic                 rx_valid,
  input  logic [BIT_WIDTH-1:0] rx_data,
  output logic [BIT_WIDTH-1:0] tx_data,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [BIT_WIDTH-1:0] bus_wdata,
  input  logic                 bus_ack,
  input  logic [BIT_WIDTH-1:0] bus_rdata,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_WAIT,
    WR_IDLE,
    WR_REQ,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  state_t               state;
  logic                 cs_q;
  logic [ADDR_W-1:0]    addr;
  logic [3:0]           frame_cnt;
  logic [BIT_WIDTH-1:0] status;
  logic                 frame_end;

  always_comb begin
    status                = '0;
    status[BIT_WIDTH-1]   = overrun;
    status[BIT_WIDTH-2]   = bus_req;
    status[3:0]           = frame_cnt;
  end

  // Frame end is level-based so it also wins over a coincident rx_valid.
  assign frame_end = !cs_active && (state != IDLE) && (state != DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cs_q      <= 1'b0;
      addr      <= '0;
      frame_cnt <= '0;
      tx_data   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      overrun   <= 1'b0;
    end else begin
      cs_q <= cs_active;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 4'd1;
        if (bus_req && !bus_ack) begin
          state <= DRAIN;
        end else begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            tx_data <= status;
            if (cs_active && !cs_q) state <= CMD;
          end
          CMD: begin
            if (rx_valid) begin
              overrun <= 1'b0;
              addr    <= rx_data[ADDR_W-1:0];
              if (rx_data[BIT_WIDTH-1]) begin
                bus_req  <= 1'b1;
                bus_we   <= 1'b0;
                bus_addr <= rx_data[ADDR_W-1:0];
                state    <= RD_REQ;
              end else begin
                state <= WR_IDLE;
              end
            end
          end
          RD_REQ: begin
            // A byte boundary here ships the stale prefetch; the request still completes.
            if (rx_valid) overrun <= 1'b1;
            if (bus_ack) begin
              bus_req <= 1'b0;
              tx_data <= bus_rdata;
              addr    <= addr + ADDR_STEP;
              state   <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (rx_valid) begin
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= addr;
              state    <= RD_REQ;
            end
          end
          WR_IDLE: begin
            if (rx_valid) begin
              bus_req   <= 1'b1;
              bus_we    <= 1'b1;
              bus_addr  <= addr;
              bus_wdata <= rx_data;
              state     <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (rx_valid) overrun <= 1'b1;
            if (bus_ack) begin
              bus_req <= 1'b0;
              addr    <= addr + ADDR_STEP;
              state   <= WR_IDLE;
            end
          end
          DRAIN: begin
            if (bus_ack) begin
              bus_req <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
